// File: rtl/octane_regmap_pkg.sv
// Register-map definitions shared by the SPI write path and the synth core:
// field widths, the control register, parameter ids and the decoded write record.
package octane_regmap_pkg;

   localparam int unsigned PARAM_ID_W     = 5;
   localparam int unsigned VOICE_W        = 5;
   localparam int unsigned OP_W           = 3;
   localparam logic [15:0] CTRL_REG_NUM   = 16'h1F00;
   localparam int unsigned CTRL_CLEAR_BIT = 0;

   typedef enum logic [PARAM_ID_W-1:0] {
      PARAM_FREQ        = 5'd0,
      PARAM_DETUNE      = 5'd1,
      PARAM_LEVEL       = 5'd2,
      PARAM_ENV_ATTACK  = 5'd3,
      PARAM_ENV_DECAY   = 5'd4,
      PARAM_ENV_SUSTAIN = 5'd5,
      PARAM_ENV_RELEASE = 5'd6,
      PARAM_FEEDBACK    = 5'd7
   } param_id_e;

   typedef struct packed {
      logic [PARAM_ID_W-1:0] id;
      logic [VOICE_W-1:0]    voice;
      logic [OP_W-1:0]       op;
      logic [15:0]           value;
   } param_write_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; o_Data presents the head entry whenever not empty.
// A push into a full FIFO is accepted only when a pop frees the slot on the same edge.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             i_Clock,
   input  logic             i_Reset_n,
   input  logic             i_Push,
   input  logic [WIDTH-1:0] i_Data,
   input  logic             i_Pop,
   output logic [WIDTH-1:0] o_Data,
   output logic             o_Full,
   output logic             o_Empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_Mem [DEPTH];
   logic [AW:0]      r_WrPtr;
   logic [AW:0]      r_RdPtr;
   logic             w_DoPush;
   logic             w_DoPop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign o_Empty  = (r_WrPtr == r_RdPtr);
   assign o_Full   = (r_WrPtr[AW-1:0] == r_RdPtr[AW-1:0]) && (r_WrPtr[AW] != r_RdPtr[AW]);
   assign w_DoPop  = i_Pop && !o_Empty;
   assign w_DoPush = i_Push && (!o_Full || w_DoPop);
   assign o_Data   = r_Mem[r_RdPtr[AW-1:0]];

   always_ff @(posedge i_Clock) begin
      if (!i_Reset_n) begin
         r_WrPtr <= '0;
         r_RdPtr <= '0;
      end else begin
         if (w_DoPush) r_WrPtr <= r_WrPtr + 1'b1;
         if (w_DoPop)  r_RdPtr <= r_RdPtr + 1'b1;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (w_DoPush) r_Mem[r_WrPtr[AW-1:0]] <= i_Data;
   end

endmodule

// File: rtl/register_write_router.sv
// Turns level-style SPI register writes into single decoded events, buffers them,
// and hands them to the core's parameter RAM over valid/ready. Errors are tallied locally.
module register_write_router
   import octane_regmap_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned NUM_OPERATORS = 6,
   parameter int unsigned NUM_PARAMS    = 8
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset_n,
   input  logic                  i_RegisterWriteEnable,
   input  logic [15:0]           i_RegisterWriteNumber,
   input  logic [15:0]           i_RegisterWriteValue,
   output logic                  o_ParamValid,
   input  logic                  i_ParamReady,
   output logic [PARAM_ID_W-1:0] o_ParamId,
   output logic [VOICE_W-1:0]    o_Voice,
   output logic [OP_W-1:0]       o_Operator,
   output logic [15:0]           o_ParamValue,
   output logic [7:0]            o_InvalidCount,
   output logic                  o_Overflow
);

   logic         r_EnableLast;
   logic [7:0]   r_InvalidCount;
   logic         r_Overflow;
   param_write_t r_LastOut;

   param_write_t w_Decoded;
   param_write_t w_Head;
   param_write_t w_Out;
   logic         w_Event;
   logic         w_IsCtrl;
   logic         w_IsValid;
   logic         w_IsInvalid;
   logic         w_Clear;
   logic         w_Pop;
   logic         w_PushReq;
   logic         w_Drop;
   logic         w_Full;
   logic         w_Empty;

   assign w_Event = i_RegisterWriteEnable && !r_EnableLast;

   assign w_Decoded.id    = i_RegisterWriteNumber[12:8];
   assign w_Decoded.voice = i_RegisterWriteNumber[7:3];
   assign w_Decoded.op    = i_RegisterWriteNumber[2:0];
   assign w_Decoded.value = i_RegisterWriteValue;

   assign w_IsCtrl    = (i_RegisterWriteNumber == CTRL_REG_NUM);
   assign w_IsValid   = (i_RegisterWriteNumber[15:13] == 3'b000)
                     && (32'(w_Decoded.id) < NUM_PARAMS)
                     && (32'(w_Decoded.op) < NUM_OPERATORS);
   assign w_IsInvalid = w_Event && !w_IsValid && !w_IsCtrl;
   assign w_Clear     = w_Event && w_IsCtrl && i_RegisterWriteValue[CTRL_CLEAR_BIT];

   assign w_Pop     = !w_Empty && i_ParamReady;
   assign w_PushReq = w_Event && w_IsValid;
   assign w_Drop    = w_PushReq && w_Full && !w_Pop;

   sync_fifo #(
      .WIDTH ($bits(param_write_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_Clock   (i_Clock),
      .i_Reset_n (i_Reset_n),
      .i_Push    (w_PushReq),
      .i_Data    (w_Decoded),
      .i_Pop     (w_Pop),
      .o_Data    (w_Head),
      .o_Full    (w_Full),
      .o_Empty   (w_Empty)
   );

   // Enable-last resets high so a command already held at reset release is ignored.
   always_ff @(posedge i_Clock) begin
      if (!i_Reset_n) begin
         r_EnableLast   <= 1'b1;
         r_InvalidCount <= '0;
         r_Overflow     <= 1'b0;
         r_LastOut      <= '0;
      end else begin
         r_EnableLast <= i_RegisterWriteEnable;
         if (w_Pop) r_LastOut <= w_Head;
         if (w_Clear) begin
            r_InvalidCount <= '0;
            r_Overflow     <= 1'b0;
         end else begin
            if (w_IsInvalid && (r_InvalidCount != 8'hFF)) r_InvalidCount <= r_InvalidCount + 8'd1;
            if (w_Drop) r_Overflow <= 1'b1;
         end
      end
   end

   // Once drained, keep presenting the last handed-off write rather than stale RAM.
   assign w_Out          = w_Empty ? r_LastOut : w_Head;
   assign o_ParamValid   = !w_Empty;
   assign o_ParamId      = w_Out.id;
   assign o_Voice        = w_Out.voice;
   assign o_Operator     = w_Out.op;
   assign o_ParamValue   = w_Out.value;
   assign o_InvalidCount = r_InvalidCount;
   assign o_Overflow     = r_Overflow;

endmodule

// File: tb/tb_register_write_router.sv
// Randomized and directed bench for register_write_router against a queue-based
// model of the register-write rules; outputs sampled on the falling edge.
module tb_register_write_router;
   import octane_regmap_pkg::*;

   logic        i_Clock = 1'b0;
   logic        i_Reset_n;
   logic        i_RegisterWriteEnable;
   logic [15:0] i_RegisterWriteNumber;
   logic [15:0] i_RegisterWriteValue;
   logic        i_ParamReady;
   logic        o_ParamValid;
   logic [4:0]  o_ParamId;
   logic [4:0]  o_Voice;
   logic [2:0]  o_Operator;
   logic [15:0] o_ParamValue;
   logic [7:0]  o_InvalidCount;
   logic        o_Overflow;

   always #5 i_Clock = ~i_Clock;

   register_write_router dut (
      .i_Clock               (i_Clock),
      .i_Reset_n             (i_Reset_n),
      .i_RegisterWriteEnable (i_RegisterWriteEnable),
      .i_RegisterWriteNumber (i_RegisterWriteNumber),
      .i_RegisterWriteValue  (i_RegisterWriteValue),
      .o_ParamValid          (o_ParamValid),
      .i_ParamReady          (i_ParamReady),
      .o_ParamId             (o_ParamId),
      .o_Voice               (o_Voice),
      .o_Operator            (o_Operator),
      .o_ParamValue          (o_ParamValue),
      .o_InvalidCount        (o_InvalidCount),
      .o_Overflow            (o_Overflow)
   );

   typedef struct {
      int id;
      int voice;
      int op;
      int value;
   } mwrite_t;

   int      n_checks = 0;
   int      n_errors = 0;
   mwrite_t m_q[$];
   bit      m_known = 1'b0;
   bit      m_en_last = 1'b1;
   int      m_inv = 0;
   bit      m_ovf = 1'b0;
   int      hs_count = 0;
   int      rdy_mode = 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic pick_ready();
      if (rdy_mode == 0) return 1'b0;
      if (rdy_mode == 1) return 1'b1;
      return ($urandom_range(0, 3) != 0);
   endfunction

   task automatic compare();
      check("valid", 32'(o_ParamValid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         check("head_id",    32'(o_ParamId),    32'(m_q[0].id));
         check("head_voice", 32'(o_Voice),      32'(m_q[0].voice));
         check("head_op",    32'(o_Operator),   32'(m_q[0].op));
         check("head_value", 32'(o_ParamValue), 32'(m_q[0].value));
      end
      check("invalid_count", 32'(o_InvalidCount), 32'(m_inv));
      check("overflow",      32'(o_Overflow),     32'(m_ovf));
   endtask

   // Effect of one rising edge on the register-write rules.
   task automatic model_edge(input logic en, input logic [15:0] num, input logic [15:0] val,
                             input logic rdy, input logic rst_n);
      int      id, voice, op, res;
      mwrite_t w;
      mwrite_t tmp;
      if (!rst_n) begin
         m_q.delete();
         m_inv     = 0;
         m_ovf     = 1'b0;
         m_en_last = 1'b1;
         m_known   = 1'b1;
         return;
      end
      if (rdy && m_q.size() > 0) tmp = m_q.pop_front();
      if (en && !m_en_last) begin
         res   = int'(num) / 8192;
         id    = (int'(num) / 256) % 32;
         voice = (int'(num) / 8) % 32;
         op    = int'(num) % 8;
         if (num == 16'h1F00) begin
            if (val[0]) begin
               m_inv = 0;
               m_ovf = 1'b0;
            end
         end else if (res == 0 && id < 8 && op < 6) begin
            w.id = id; w.voice = voice; w.op = op; w.value = int'(val);
            if (m_q.size() < 4) m_q.push_back(w);
            else m_ovf = 1'b1;
         end else if (m_inv < 255) begin
            m_inv++;
         end
      end
      m_en_last = en;
   endtask

   task automatic step(input logic en, input logic [15:0] num, input logic [15:0] val,
                       input logic rst_n);
      logic rdy;
      rdy = pick_ready();
      if (m_known) compare();
      if (m_known && rst_n && o_ParamValid && rdy) hs_count++;
      i_Reset_n             = rst_n;
      i_RegisterWriteEnable = en;
      i_RegisterWriteNumber = num;
      i_RegisterWriteValue  = val;
      i_ParamReady          = rdy;
      model_edge(en, num, val, rdy, rst_n);
      @(posedge i_Clock);
      @(negedge i_Clock);
   endtask

   task automatic write(input logic [15:0] num, input logic [15:0] val, input int hi, input int lo);
      repeat (hi) step(1'b1, num, val, 1'b1);
      repeat (lo) step(1'b0, num, val, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 16'h0000, 16'h0000, 1'b1);
   endtask

   initial begin
      logic [15:0] num;
      i_Reset_n = 1'b0; i_RegisterWriteEnable = 1'b0;
      i_RegisterWriteNumber = '0; i_RegisterWriteValue = '0; i_ParamReady = 1'b0;
      rdy_mode = 1;
      step(1'b0, 16'h0, 16'h0, 1'b0);
      step(1'b0, 16'h0, 16'h0, 1'b0);
      check("rst_valid", 32'(o_ParamValid),   32'd0);
      check("rst_id",    32'(o_ParamId),      32'd0);
      check("rst_voice", 32'(o_Voice),        32'd0);
      check("rst_op",    32'(o_Operator),     32'd0);
      check("rst_value", 32'(o_ParamValue),   32'd0);
      check("rst_inv",   32'(o_InvalidCount), 32'd0);
      check("rst_ovf",   32'(o_Overflow),     32'd0);

      // Long-held enable: one event, visible right after the rising edge.
      idle(2);
      hs_count = 0;
      step(1'b1, 16'h0203, 16'hABCD, 1'b1);
      check("t1_latency", 32'(o_ParamValid), 32'd1);
      check("t1_id",      32'(o_ParamId),    32'd2);
      check("t1_voice",   32'(o_Voice),      32'd0);
      check("t1_op",      32'(o_Operator),   32'd3);
      check("t1_value",   32'(o_ParamValue), 32'hABCD);
      repeat (299) step(1'b1, 16'h0203, 16'hABCD, 1'b1);
      idle(3);
      check("t1_handshakes", 32'(hs_count), 32'd1);

      write(16'h0006, 16'h1111, 2, 2);
      check("inv_op6", 32'(o_InvalidCount), 32'd1);
      write(16'h2000, 16'h2222, 2, 2);
      check("inv_reserved", 32'(o_InvalidCount), 32'd2);
      write(16'h0800, 16'h3333, 2, 2);
      check("inv_id8", 32'(o_InvalidCount), 32'd3);
      check("inv_no_valid", 32'(o_ParamValid), 32'd0);
      repeat (260) write(16'h0006, 16'h0, 1, 1);
      check("inv_saturate", 32'(o_InvalidCount), 32'd255);

      // Stalled core: fifth write overflows, first four drain in order.
      rdy_mode = 0;
      for (int v = 1; v <= 5; v++) write(16'h0109, 16'(v), 1, 1);
      check("ovf_set", 32'(o_Overflow), 32'd1);
      rdy_mode = 1;
      for (int i = 0; i < 4; i++) begin
         check("drain_valid", 32'(o_ParamValid), 32'd1);
         check("drain_order", 32'(o_ParamValue), 32'(i + 1));
         idle(1);
      end
      check("drain_empty", 32'(o_ParamValid), 32'd0);

      write(16'h1F00, 16'h0001, 1, 1);
      check("ctrl_clr_inv",  32'(o_InvalidCount), 32'd0);
      check("ctrl_clr_ovf",  32'(o_Overflow),     32'd0);
      check("ctrl_no_entry", 32'(o_ParamValid),   32'd0);

      // Full FIFO with a pop on the event edge: push accepted, no overflow.
      rdy_mode = 0;
      for (int v = 0; v < 4; v++) write(16'h0411, 16'(16'h11 + v), 1, 1);
      rdy_mode = 1;
      step(1'b1, 16'h0305, 16'h0015, 1'b1);
      rdy_mode = 0;
      step(1'b0, 16'h0305, 16'h0015, 1'b1);
      check("full_pop_ovf", 32'(o_Overflow), 32'd0);
      rdy_mode = 1;
      hs_count = 0;
      idle(6);
      check("full_pop_count", 32'(hs_count), 32'd4);

      write(16'h1F20, 16'h0001, 1, 1);
      check("ctrl_nonzero_invalid", 32'(o_InvalidCount), 32'd1);

      // Reset with queued entries and enable held through release.
      rdy_mode = 0;
      for (int v = 0; v < 3; v++) write(16'h0512, 16'(16'h40 + v), 1, 1);
      step(1'b1, 16'h0101, 16'h0077, 1'b0);
      step(1'b1, 16'h0101, 16'h0077, 1'b0);
      repeat (5) step(1'b1, 16'h0101, 16'h0077, 1'b1);
      check("rst_mid_empty", 32'(o_ParamValid),   32'd0);
      check("rst_mid_inv",   32'(o_InvalidCount), 32'd0);
      step(1'b0, 16'h0101, 16'h0077, 1'b1);
      step(1'b1, 16'h0101, 16'h0077, 1'b1);
      check("rst_rearm_valid", 32'(o_ParamValid), 32'd1);
      check("rst_rearm_value", 32'(o_ParamValue), 32'h0077);
      rdy_mode = 1;
      idle(3);

      // Random traffic with random backpressure and occasional stalls.
      for (int t = 0; t < 250; t++) begin
         int kind;
         kind = $urandom_range(0, 9);
         if (kind <= 6)
            num = {3'b000, 5'($urandom_range(0, 7)), 5'($urandom), 3'($urandom_range(0, 5))};
         else if (kind <= 8)
            num = 16'($urandom);
         else
            num = 16'h1F00;
         rdy_mode = ($urandom_range(0, 4) == 0) ? 0 : 2;
         write(num, 16'($urandom), $urandom_range(1, 3), $urandom_range(1, 3));
      end
      rdy_mode = 1;
      idle(8);
      check("final_empty", 32'(o_ParamValid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/register_write_router.md
Name: register_write_router

Overview:
- Sits directly downstream of the SPI slave. Consumes its level-style register-write outputs (enable, 16-bit number, 16-bit value).
- Detects each new write and decodes the number into parameter / voice / operator.
- Buffers decoded writes in a small FIFO and hands them to the synth core's parameter RAM with a valid/ready handshake, because the core accepts writes only in idle slots.
- Handles invalid writes, overflow and control-register writes locally.

Parameters:
- FIFO_DEPTH, 4, decoded-write buffer entries (power of 2, ≥2)
- NUM_OPERATORS, 6, valid operator indices 0..NUM_OPERATORS-1
- NUM_PARAMS, 8, valid parameter ids 0..NUM_PARAMS-1

Ports:
- i_Clock  in  1  system clock
- i_Reset_n  in  1  reset, synchronous, active-low
- i_RegisterWriteEnable  in  1  level; high while a complete 32-bit command is held
- i_RegisterWriteNumber  in  16  register number
- i_RegisterWriteValue  in  16  register value
- o_ParamValid  out  1  decoded write available
- i_ParamReady  in  1  core accepts write this cycle
- o_ParamId  out  5  parameter id
- o_Voice  out  5  voice index
- o_Operator  out  3  operator index
- o_ParamValue  out  16  value
- o_InvalidCount  out  8  saturating count of rejected writes
- o_Overflow  out  1  sticky: a valid write was dropped because the FIFO was full

Behaviour:
- Reset (i_Reset_n low at a rising edge):
  - FIFO emptied; o_ParamValid=0.
  - o_ParamId, o_Voice, o_Operator, o_ParamValue = 0.
  - o_InvalidCount=0, o_Overflow=0; edge-detect register=1.
  - Applies mid-operation: buffered entries are discarded.
- Edge detect:
  - A write event occurs when r_EnableLast==0 && i_RegisterWriteEnable==1.
  - An enable held high for many cycles produces exactly one event.
  - Edge-detect register resets to 1, so an enable already high at reset release produces no event.
- Decode, sampled on the event cycle:
  - number[15:13] reserved; number[12:8]=param id; [7:3]=voice; [2:0]=operator.
  - Valid when reserved==0 && id<NUM_PARAMS && op<NUM_OPERATORS.
  - Control register CTRL = number 0x1F00, i.e. id 31 with voice and operator ignored but required 0.
  - Anything else is invalid: o_InvalidCount increments, saturating at 255, and nothing is pushed.
- Control writes:
  - Consumed locally; never enter the FIFO.
  - value[0]=1 clears o_InvalidCount and o_Overflow at the next edge.
  - If an increment or overflow coincides with a clear, the clear wins.
- Push:
  - A valid event pushes {id, voice, op, value} at the event edge.
  - FIFO full at that edge: the write is dropped and o_Overflow is set.
  - Exception: if a pop occurs on the same edge, the push succeeds and no overflow is flagged.
- Output:
  - Show-ahead FIFO. o_ParamValid = !empty. Outputs reflect the head entry.
  - Pop when o_ParamValid && i_ParamReady.
  - Latency: event at edge k → o_ParamValid high after edge k, i.e. visible in cycle k+1 when the FIFO was empty.
  - Outputs are stable while o_ParamValid && !i_ParamReady.
  - When empty, outputs hold their last values; the values are don't-care for the consumer.
- Order: strict FIFO; no coalescing of repeated writes to the same register.
- Throughput: 1 event per 2 cycles maximum, because of the edge detect. Back-to-back SPI commands are ≥33 SCK periods apart (≥264 clocks), so overflow implies a stalled core.

Decomposition:
- octane_regmap_pkg:
  - PARAM_ID_W=5, VOICE_W=5, OP_W=3
  - CTRL_REG_NUM=16'h1F00, CTRL_CLEAR_BIT=0
  - param id enum (e.g. PARAM_FREQ, PARAM_ENV_ATTACK, …)
  - packed struct param_write_t {id, voice, op, value}
- Sub-module sync_fifo:
  - parameterised width/depth, show-ahead, push/pop/full/empty, synchronous active-low reset.
  - Instantiated with a param_write_t payload.

Test Plan:
- Reset → all outputs 0. Then enable rises with number=0x0203, value=0xABCD, held 300 cycles → exactly one handshake: id=2, voice=0, op=3, value=0xABCD; valid visible one cycle after the rise.
- Invalid writes:
  - 0x0006 (op 6) → o_InvalidCount=1, no valid.
  - 0x2000 (reserved bit) → 2.
  - 0x0800 (id 8) → 3.
  - 260 further invalid writes → count saturates at 255.
- i_ParamReady=0, push 5 valid writes with values 1..5 → o_Overflow=1. Release ready → values 1,2,3,4 in order, then valid low.
- FIFO full with ready=1 on the same edge as a new event → push accepted, o_Overflow stays 0, 4 entries remain.
- Write CTRL 0x1F00 value 0x0001 after errors → count=0 and overflow=0 next cycle, nothing enters the FIFO. Write 0x1F20 → counted as invalid.
- Reset asserted with 3 entries queued, and enable high through reset release → FIFO empty, no spurious event until enable falls and rises again.
